blake2_controller: RTL and testbench

//  Input-side controller for a BLAKE2 hash core.
//  - Packs BUS_WIDTH-bit words from a narrow stream into a message buffer of up to MAX_BLOCKS blocks.
//  - On request, sequences the core through init -> next per block (last one flagged final_block) -> digest.
//  - Sits between the data source and the BLAKE2 core. Presents one BLOCK_WIDTH block and the message length to the core.

---
 rtl/blake2_controller.sv | 143 ++++++++++++++
 tb/tb_blake2_controller.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/blake2_controller.sv
// Input-side controller for a BLAKE2 core: packs narrow words into a block buffer and sequences
// init/next/digest. Optional macro CONTROLLER_AUTO_START_EN starts hashing when the buffer fills.
module blake2_controller #(
  parameter int unsigned BUS_WIDTH   = 2,
  parameter int unsigned BLOCK_WIDTH = 16,
  parameter int unsigned MAX_BLOCKS  = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   valid_in,
  input  logic [BUS_WIDTH-1:0]   din,
  input  logic                   new_hash_request,
  input  logic                   hash_ready,
  input  logic                   digest_valid,
  output logic                   init,
  output logic                   next,
  output logic                   final_block,
  output logic [BLOCK_WIDTH-1:0] block,
  output logic [127:0]           data_length,
  output logic                   hash_started,
  output logic                   cont_buf_empty,
  output logic                   cont_buf_full
);

  localparam int unsigned Wpb  = BLOCK_WIDTH / BUS_WIDTH;
  localparam int unsigned Cap  = MAX_BLOCKS * Wpb;
  localparam int unsigned CntW = $clog2(Cap + 1);
  localparam int unsigned BlkW = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;
  localparam int unsigned BufW = MAX_BLOCKS * BLOCK_WIDTH;
  localparam logic [CntW-1:0] CapW = CntW'(Cap);

  typedef enum logic [2:0] {StIdle, StInit, StWaitRdy, StNext, StWaitDig} state_e;

  state_e                 state_q;
  logic [CntW-1:0]        wcnt_q, wcnt_d;
  logic [BufW-1:0]        buf_q, buf_d;
  logic [BlkW-1:0]        blk_q;
  logic                   init_q, next_q, final_q, started_q, empty_q, full_q;
  logic [BLOCK_WIDTH-1:0] block_q;
  logic [127:0]           len_q;

  logic                   accept, start, last_blk;
  logic [31:0]            wr_lsb, rd_lsb;
  logic [CntW-1:0]        nblk;
  logic [BLOCK_WIDTH-1:0] blk_sel;

`ifdef CONTROLLER_AUTO_START_EN
  assign start = new_hash_request || full_q;
`else
  assign start = new_hash_request;
`endif

  always_comb begin
    accept = (state_q == StIdle) && valid_in && !full_q;
    wr_lsb = 32'(wcnt_q) * BUS_WIDTH;
    rd_lsb = 32'(blk_q) * BLOCK_WIDTH;
    wcnt_d = wcnt_q;
    buf_d  = buf_q;
    if (accept) begin
      buf_d[wr_lsb +: BUS_WIDTH] = din;
      wcnt_d = wcnt_q + 1'b1;
    end
    if (state_q == StWaitDig && digest_valid) begin
      wcnt_d = '0;
      buf_d  = '0;
    end
    // An empty message still sends one all-zero final block.
    nblk     = (wcnt_q == '0) ? CntW'(1) : CntW'((32'(wcnt_q) + Wpb - 1) / Wpb);
    last_blk = (CntW'(blk_q) == nblk - CntW'(1));
    blk_sel  = buf_q[rd_lsb +: BLOCK_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      wcnt_q    <= '0;
      buf_q     <= '0;
      blk_q     <= '0;
      init_q    <= 1'b0;
      next_q    <= 1'b0;
      final_q   <= 1'b0;
      block_q   <= '0;
      started_q <= 1'b0;
      empty_q   <= 1'b1;
      full_q    <= 1'b0;
      len_q     <= '0;
    end else begin
      wcnt_q  <= wcnt_d;
      buf_q   <= buf_d;
      empty_q <= (wcnt_d == '0);
      full_q  <= (wcnt_d == CapW);
      len_q   <= 128'(32'(wcnt_d) * BUS_WIDTH);
      init_q  <= 1'b0;
      next_q  <= 1'b0;
      final_q <= 1'b0;
      block_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StInit;
            init_q    <= 1'b1;
            started_q <= 1'b1;
            blk_q     <= '0;
          end
        end
        StInit: state_q <= StWaitRdy;
        StWaitRdy: begin
          if (hash_ready) begin
            state_q <= StNext;
            next_q  <= 1'b1;
            block_q <= blk_sel;
            final_q <= last_blk;
          end
        end
        StNext: begin
          if (last_blk) begin
            state_q <= StWaitDig;
          end else begin
            blk_q   <= blk_q + 1'b1;
            state_q <= StWaitRdy;
          end
        end
        StWaitDig: begin
          if (digest_valid) begin
            state_q   <= StIdle;
            started_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign init           = init_q;
  assign next           = next_q;
  assign final_block    = final_q;
  assign block          = block_q;
  assign data_length    = len_q;
  assign hash_started   = started_q;
  assign cont_buf_empty = empty_q;
  assign cont_buf_full  = full_q;

endmodule

// File: tb/tb_blake2_controller.sv
// Directed self-checking bench for blake2_controller (default parameters).
module tb_blake2_controller;

  logic         clk = 1'b0;
  logic         reset_n, valid_in, new_hash_request, hash_ready, digest_valid;
  logic [1:0]   din;
  logic         init, next, final_block, hash_started, cont_buf_empty, cont_buf_full;
  logic [15:0]  block;
  logic [127:0] data_length;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  blake2_controller dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .valid_in         (valid_in),
    .din              (din),
    .new_hash_request (new_hash_request),
    .hash_ready       (hash_ready),
    .digest_valid     (digest_valid),
    .init             (init),
    .next             (next),
    .final_block      (final_block),
    .block            (block),
    .data_length      (data_length),
    .hash_started     (hash_started),
    .cont_buf_empty   (cont_buf_empty),
    .cont_buf_full    (cont_buf_full)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One hash_ready pulse from WAIT_RDY, then check the resulting next pulse and its drop.
  task automatic do_block(input string tag, input logic [15:0] exp_blk, input logic exp_fin);
    hash_ready = 1'b1;
    tick();
    hash_ready = 1'b0;
    chk({tag, "_next"}, 128'(next), 128'(1));
    chk({tag, "_block"}, 128'(block), 128'(exp_blk));
    chk({tag, "_final"}, 128'(final_block), 128'(exp_fin));
    tick();
    chk({tag, "_next_drop"}, 128'(next), 128'(0));
    chk({tag, "_block_drop"}, 128'(block), 128'(0));
  endtask

  task automatic do_digest(input string tag);
    digest_valid = 1'b1;
    tick();
    digest_valid = 1'b0;
    chk({tag, "_started"}, 128'(hash_started), 128'(0));
    chk({tag, "_empty"}, 128'(cont_buf_empty), 128'(1));
  endtask

  task automatic request(input string tag);
    new_hash_request = 1'b1;
    tick();
    new_hash_request = 1'b0;
    chk({tag, "_init"}, 128'(init), 128'(1));
    chk({tag, "_started"}, 128'(hash_started), 128'(1));
    tick();
    chk({tag, "_init_drop"}, 128'(init), 128'(0));
  endtask

  initial begin
    reset_n = 1'b0; valid_in = 1'b0; din = '0;
    new_hash_request = 1'b0; hash_ready = 1'b0; digest_valid = 1'b0;

    // Reset
    tick(); tick();
    reset_n = 1'b1;
    chk("rst_init", 128'(init), 128'(0));
    chk("rst_next", 128'(next), 128'(0));
    chk("rst_final", 128'(final_block), 128'(0));
    chk("rst_started", 128'(hash_started), 128'(0));
    chk("rst_empty", 128'(cont_buf_empty), 128'(1));
    chk("rst_full", 128'(cont_buf_full), 128'(0));
    chk("rst_len", data_length, 128'(0));

    // Partial message: 15 words 0,1,2,3,...
    for (int i = 0; i < 15; i++) begin
      valid_in = 1'b1; din = 2'(i % 4);
      tick();
    end
    valid_in = 1'b0;
    chk("part_empty", 128'(cont_buf_empty), 128'(0));
    request("part");
    chk("part_len", data_length, 128'(30));
    do_block("part_b0", 16'hE4E4, 1'b0);
    // Words 8..14 are 0,1,2,3,0,1,2; the top word slot stays zero.
    do_block("part_b1", 16'h24E4, 1'b1);
    do_digest("part_dig");

    // Fill: block b holds word value b everywhere
    for (int i = 0; i < 32; i++) begin
      valid_in = 1'b1; din = 2'(i / 8);
      tick();
    end
    chk("fill_full", 128'(cont_buf_full), 128'(1));
    chk("fill_len", data_length, 128'(64));
    din = 2'd1;
    new_hash_request = 1'b1;
    tick();
    valid_in = 1'b0; new_hash_request = 1'b0;
    chk("fill_init", 128'(init), 128'(1));
    chk("fill_len_33", data_length, 128'(64));
    tick();
    do_block("fill_b0", 16'h0000, 1'b0);
    do_block("fill_b1", 16'h5555, 1'b0);
    do_block("fill_b2", 16'hAAAA, 1'b0);
    do_block("fill_b3", 16'hFFFF, 1'b1);
    do_digest("fill_dig");
    chk("fill_full_clr", 128'(cont_buf_full), 128'(0));

    // Empty request
    request("empty");
    chk("empty_len", data_length, 128'(0));
    do_block("empty_b0", 16'h0000, 1'b1);
    do_digest("empty_dig");

    // Busy: request and data during WAIT_RDY are ignored
    for (int i = 0; i < 3; i++) begin
      valid_in = 1'b1; din = 2'd3;
      tick();
    end
    valid_in = 1'b0;
    request("busy");
    chk("busy_len", data_length, 128'(6));
    for (int i = 0; i < 3; i++) begin
      new_hash_request = 1'b1; valid_in = 1'b1; din = 2'd1;
      tick();
      chk("busy_no_init", 128'(init), 128'(0));
      chk("busy_len_hold", data_length, 128'(6));
    end
    new_hash_request = 1'b0; valid_in = 1'b0;
    do_block("busy_b0", 16'h003F, 1'b1);
    do_digest("busy_dig");
    hash_ready = 1'b1;
    tick();
    hash_ready = 1'b0;
    chk("idle_ready_no_next", 128'(next), 128'(0));
    tick();
    chk("idle_ready_no_next2", 128'(next), 128'(0));

    // Reset mid-hash
    for (int i = 0; i < 5; i++) begin
      valid_in = 1'b1; din = 2'd1;
      tick();
    end
    valid_in = 1'b0;
    request("mid");
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("mid_started", 128'(hash_started), 128'(0));
    chk("mid_empty", 128'(cont_buf_empty), 128'(1));
    chk("mid_len", data_length, 128'(0));
    hash_ready = 1'b1;
    tick();
    hash_ready = 1'b0;
    chk("mid_no_next", 128'(next), 128'(0));

    // Full buffer with no request
    for (int i = 0; i < 32; i++) begin
      valid_in = 1'b1; din = 2'd3;
      tick();
    end
    valid_in = 1'b0;
    chk("auto_full", 128'(cont_buf_full), 128'(1));
    chk("auto_no_init_yet", 128'(init), 128'(0));
    tick();
`ifdef CONTROLLER_AUTO_START_EN
    chk("auto_init", 128'(init), 128'(1));
    chk("auto_started", 128'(hash_started), 128'(1));
`else
    chk("stall_no_init", 128'(init), 128'(0));
    chk("stall_started", 128'(hash_started), 128'(0));
    chk("stall_full", 128'(cont_buf_full), 128'(1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
